// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus bundle: issue request/response, writeback bus, two lookup ports, commit/flush.
// Combinational bundle with no latency of its own; timing belongs to the reorder_buffer block.
// No valid/ready handshake: issue is refused through rob_full, and the other groups are fire-and-forget.
// Ports:
//   master - the pipeline side. It drives issue_*, wb_* and get_rob_entry*,
//            and observes allocation, lookup and commit/flush results.
//   slave  - the reorder buffer side. It has the opposite directions.
interface reorder_buffer_if #(
    parameter int ROB_BIT = 3
);
    // issue from decoder
    logic               issue_valid;
    logic [4:0]         issue_rd;
    logic               issue_is_branch;
    logic               issue_pred_taken;
    logic [31:0]        issue_alt_pc;
    logic [ROB_BIT-1:0] issue_rob_entry;
    logic               rob_full;
    logic               rob_empty;
    // common writeback bus
    logic               wb_valid;
    logic [ROB_BIT-1:0] wb_entry;
    logic [31:0]        wb_value;
    logic               wb_taken;
    // register file dependency lookups
    logic [ROB_BIT-1:0] get_rob_entry1;
    logic [ROB_BIT-1:0] get_rob_entry2;
    logic               ready1;
    logic               ready2;
    logic [31:0]        value1;
    logic [31:0]        value2;
    // commit / flush
    logic               rob_commit;
    logic [4:0]         commit_reg_id;
    logic [31:0]        commit_reg_data;
    logic [ROB_BIT-1:0] commit_rob_entry;
    logic               rob_clear_up;
    logic [31:0]        clear_pc;

    modport master (
        output issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
        output wb_valid, wb_entry, wb_value, wb_taken,
        output get_rob_entry1, get_rob_entry2,
        input  issue_rob_entry, rob_full, rob_empty,
        input  ready1, ready2, value1, value2,
        input  rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry,
        input  rob_clear_up, clear_pc
    );

    modport slave (
        input  issue_valid, issue_rd, issue_is_branch, issue_pred_taken, issue_alt_pc,
        input  wb_valid, wb_entry, wb_value, wb_taken,
        input  get_rob_entry1, get_rob_entry2,
        output issue_rob_entry, rob_full, rob_empty,
        output ready1, ready2, value1, value2,
        output rob_commit, commit_reg_id, commit_reg_data, commit_rob_entry,
        output rob_clear_up, clear_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer. It allocates entries at issue and captures writeback results.
// Entries commit to the register file one per cycle, and a mispredicted branch raises a flush.
// Latency: a lookup sees a writeback in the same cycle. A ready head commits one edge after its writeback edge.
// Backpressure: issue is refused while rob_full. rdy_in low freezes all state and suppresses the commit/flush pulses.
// Ports:
//   clk_in, rst_in (async, active-high) and rdy_in (global stall) are plain scalars.
//   rob (reorder_buffer_if.slave) carries issue, writeback, the two lookups, and commit/flush outputs.
module reorder_buffer #(
    parameter int ROB_BIT = 3
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 2 ** ROB_BIT;
    localparam logic [ROB_BIT:0] FULL_COUNT = (ROB_BIT + 1)'(DEPTH);

    // per-entry state
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] ready_q;
    logic [4:0]       rd_q         [DEPTH];
    logic             is_branch_q  [DEPTH];
    logic             pred_taken_q [DEPTH];
    logic             taken_q      [DEPTH];
    logic [31:0]      alt_pc_q     [DEPTH];
    logic [31:0]      value_q      [DEPTH];

    logic [ROB_BIT-1:0] head_q;
    logic [ROB_BIT-1:0] tail_q;
    logic [ROB_BIT:0]   count_q;

    logic flush_cycle;
    logic do_issue;
    logic do_wb;
    logic do_commit;
    logic mispredict;
    logic hit1;
    logic hit2;

    // Full is decoded from the registered count only. A commit on the same
    // edge therefore never lets an issue into the slot it is freeing.
    assign rob.rob_full        = (count_q == FULL_COUNT);
    assign rob.rob_empty       = (count_q == '0);
    assign rob.issue_rob_entry = tail_q;

    always_comb begin
        // The cycle after a flush edge still shows rob_clear_up. Anything the
        // front end sends in that cycle belongs to the squashed path.
        flush_cycle = rob.rob_clear_up;
        do_issue    = rdy_in && !flush_cycle && rob.issue_valid && !rob.rob_full;
        do_wb       = rdy_in && !flush_cycle && rob.wb_valid && valid_q[rob.wb_entry];
        // Commit looks only at the stored ready bit. A writeback arriving for
        // the head in this cycle commits one edge later.
        do_commit   = rdy_in && valid_q[head_q] && ready_q[head_q];
        mispredict  = do_commit && is_branch_q[head_q]
                      && (taken_q[head_q] != pred_taken_q[head_q]);
    end

    // Lookups: the live writeback bus wins over the stored value.
    always_comb begin
        hit1       = rob.wb_valid && (rob.wb_entry == rob.get_rob_entry1);
        hit2       = rob.wb_valid && (rob.wb_entry == rob.get_rob_entry2);
        rob.ready1 = ready_q[rob.get_rob_entry1] || hit1;
        rob.ready2 = ready_q[rob.get_rob_entry2] || hit2;
        rob.value1 = hit1 ? rob.wb_value : value_q[rob.get_rob_entry1];
        rob.value2 = hit2 ? rob.wb_value : value_q[rob.get_rob_entry2];
    end

    // Control state, pointers and registered commit/flush outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q              <= '0;
            ready_q              <= '0;
            head_q               <= '0;
            tail_q               <= '0;
            count_q              <= '0;
            rob.rob_commit       <= 1'b0;
            rob.commit_reg_id    <= '0;
            rob.commit_reg_data  <= '0;
            rob.commit_rob_entry <= '0;
            rob.rob_clear_up     <= 1'b0;
            rob.clear_pc         <= '0;
        end else if (!rdy_in) begin
            // Stalled: hold everything, and end any pulse so a commit is never reported twice.
            rob.rob_commit   <= 1'b0;
            rob.rob_clear_up <= 1'b0;
        end else begin
            rob.rob_commit   <= do_commit;
            rob.rob_clear_up <= mispredict;

            if (do_commit) begin
                rob.commit_reg_id    <= is_branch_q[head_q] ? 5'd0 : rd_q[head_q];
                rob.commit_reg_data  <= value_q[head_q];
                rob.commit_rob_entry <= head_q;
            end

            if (mispredict) begin
                // A same-edge issue or writeback is squashed along with everything else.
                rob.clear_pc <= alt_pc_q[head_q];
                valid_q      <= '0;
                ready_q      <= '0;
                head_q       <= '0;
                tail_q       <= '0;
                count_q      <= '0;
            end else begin
                if (do_issue) begin
                    valid_q[tail_q] <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    tail_q          <= tail_q + 1'b1;
                end
                if (do_wb) begin
                    ready_q[rob.wb_entry] <= 1'b1;
                end
                // Placed after the writeback so a late result for the retiring head cannot revive it.
                if (do_commit) begin
                    valid_q[head_q] <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                    head_q          <= head_q + 1'b1;
                end
                case ({do_issue, do_commit})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Entry payload. Valid/ready qualify it, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (do_issue) begin
            rd_q[tail_q]         <= rob.issue_rd;
            is_branch_q[tail_q]  <= rob.issue_is_branch;
            pred_taken_q[tail_q] <= rob.issue_pred_taken;
            alt_pc_q[tail_q]     <= rob.issue_alt_pc;
        end
        if (do_wb) begin
            value_q[rob.wb_entry] <= rob.wb_value;
            taken_q[rob.wb_entry] <= rob.wb_taken;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a table of per-cycle vectors plus directed multi-cycle sequences.
// Inputs are driven just after the falling edge, and outputs are sampled 1 ns later, away from the rising edge.
// Each row's expectations are the outputs visible during that cycle, before the next rising edge.
module tb_reorder_buffer;
    localparam int ROB_BIT = 3;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    int   checks = 0;
    int   errors = 0;

    reorder_buffer_if #(.ROB_BIT(ROB_BIT)) rob_bus ();

    reorder_buffer #(.ROB_BIT(ROB_BIT)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rob    (rob_bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic        wv;
        logic [2:0]  we;
        logic [31:0] wval;
        logic [2:0]  g1;
        logic [2:0]  e_entry;
        logic        e_full;
        logic        e_empty;
        logic        e_commit;
        logic [4:0]  e_cid;
        logic [31:0] e_cdata;
        logic [2:0]  e_cent;
        logic        e_rdy1;
        logic [31:0] e_val1;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rob_bus.issue_valid      = 1'b0;
        rob_bus.issue_rd         = '0;
        rob_bus.issue_is_branch  = 1'b0;
        rob_bus.issue_pred_taken = 1'b0;
        rob_bus.issue_alt_pc     = '0;
        rob_bus.wb_valid         = 1'b0;
        rob_bus.wb_entry         = '0;
        rob_bus.wb_value         = '0;
        rob_bus.wb_taken         = 1'b0;
        rob_bus.get_rob_entry1   = '0;
        rob_bus.get_rob_entry2   = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk_in);
        idle_inputs();
    endtask

    task automatic drive_issue(input logic [4:0] rd, input logic br, input logic pt,
                               input logic [31:0] apc);
        rob_bus.issue_valid      = 1'b1;
        rob_bus.issue_rd         = rd;
        rob_bus.issue_is_branch  = br;
        rob_bus.issue_pred_taken = pt;
        rob_bus.issue_alt_pc     = apc;
    endtask

    task automatic drive_wb(input logic [2:0] entry, input logic [31:0] val, input logic tk);
        rob_bus.wb_valid = 1'b1;
        rob_bus.wb_entry = entry;
        rob_bus.wb_value = val;
        rob_bus.wb_taken = tk;
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle_inputs();
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        // Fields: iv rd | wv we wval | g1 | entry full empty commit cid cdata cent | rdy1 val1
        vecs[0]  = '{0, 0, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0, 32'h0,  0, 0, 32'h0};
        vecs[1]  = '{1, 5, 0, 0, 32'h0,  0, 0, 0, 1, 0, 0, 32'h0,  0, 0, 32'h0};
        vecs[2]  = '{1, 6, 0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0};
        vecs[3]  = '{1, 7, 0, 0, 32'h0,  0, 2, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0};
        vecs[4]  = '{0, 0, 1, 2, 32'h22, 2, 3, 0, 0, 0, 0, 32'h0,  0, 1, 32'h22};
        vecs[5]  = '{0, 0, 1, 0, 32'h00, 2, 3, 0, 0, 0, 0, 32'h0,  0, 1, 32'h22};
        vecs[6]  = '{0, 0, 1, 1, 32'h11, 0, 3, 0, 0, 0, 0, 32'h0,  0, 1, 32'h00};
        vecs[7]  = '{0, 0, 0, 0, 32'h0,  1, 3, 0, 0, 1, 5, 32'h0,  0, 1, 32'h11};
        vecs[8]  = '{0, 0, 0, 0, 32'h0,  0, 3, 0, 0, 1, 6, 32'h11, 1, 0, 32'h0};
        vecs[9]  = '{0, 0, 0, 0, 32'h0,  0, 3, 0, 1, 1, 7, 32'h22, 2, 0, 32'h0};
        vecs[10] = '{0, 0, 0, 0, 32'h0,  0, 3, 0, 1, 0, 7, 32'h22, 2, 0, 32'h0};

        idle_inputs();
        do_reset();

        // Reset state
        #1;
        chk("rst.empty", rob_bus.rob_empty, 1);
        chk("rst.full", rob_bus.rob_full, 0);
        chk("rst.commit", rob_bus.rob_commit, 0);
        chk("rst.clear", rob_bus.rob_clear_up, 0);
        chk("rst.entry", rob_bus.issue_rob_entry, 0);
        chk("rst.clear_pc", rob_bus.clear_pc, 0);

        // Out-of-order writeback, in-order commit
        for (int i = 0; i < NV; i++) begin
            next_cycle();
            rob_bus.issue_valid    = vecs[i].iv;
            rob_bus.issue_rd       = vecs[i].rd;
            rob_bus.wb_valid       = vecs[i].wv;
            rob_bus.wb_entry       = vecs[i].we;
            rob_bus.wb_value       = vecs[i].wval;
            rob_bus.get_rob_entry1 = vecs[i].g1;
            #1;
            chk($sformatf("v%0d.entry", i), rob_bus.issue_rob_entry, vecs[i].e_entry);
            chk($sformatf("v%0d.full", i), rob_bus.rob_full, vecs[i].e_full);
            chk($sformatf("v%0d.empty", i), rob_bus.rob_empty, vecs[i].e_empty);
            chk($sformatf("v%0d.commit", i), rob_bus.rob_commit, vecs[i].e_commit);
            chk($sformatf("v%0d.cid", i), rob_bus.commit_reg_id, vecs[i].e_cid);
            chk($sformatf("v%0d.cdata", i), rob_bus.commit_reg_data, vecs[i].e_cdata);
            chk($sformatf("v%0d.cent", i), rob_bus.commit_rob_entry, vecs[i].e_cent);
            chk($sformatf("v%0d.ready1", i), rob_bus.ready1, vecs[i].e_rdy1);
            if (vecs[i].e_rdy1)
                chk($sformatf("v%0d.value1", i), rob_bus.value1, vecs[i].e_val1);
        end

        // Fill to full, refuse a 9th issue, then commit one and reissue into entry 0
        do_reset();
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            drive_issue(5'(i + 1), 1'b0, 1'b0, 32'h0);
            #1;
            chk("fill.entry", rob_bus.issue_rob_entry, 32'(i));
            chk("fill.full", rob_bus.rob_full, 0);
        end
        next_cycle();
        drive_issue(5'd31, 1'b0, 1'b0, 32'h0);
        drive_wb(3'd0, 32'hA0, 1'b0);
        #1;
        chk("full.set", rob_bus.rob_full, 1);
        chk("full.entry", rob_bus.issue_rob_entry, 0);
        next_cycle();
        drive_issue(5'd9, 1'b0, 1'b0, 32'h0);
        #1;
        chk("full.no_free_same_cycle", rob_bus.rob_full, 1);
        chk("full.no_commit_yet", rob_bus.rob_commit, 0);
        next_cycle();
        drive_issue(5'd9, 1'b0, 1'b0, 32'h0);
        #1;
        chk("wrap.commit", rob_bus.rob_commit, 1);
        chk("wrap.cid", rob_bus.commit_reg_id, 1);
        chk("wrap.cdata", rob_bus.commit_reg_data, 32'hA0);
        chk("wrap.cent", rob_bus.commit_rob_entry, 0);
        chk("wrap.full_clear", rob_bus.rob_full, 0);
        chk("wrap.entry", rob_bus.issue_rob_entry, 0);
        next_cycle();
        #1;
        chk("wrap.entry_after", rob_bus.issue_rob_entry, 1);
        chk("wrap.full_again", rob_bus.rob_full, 1);

        // Fill and drain three times against an in-order expectation
        do_reset();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                next_cycle();
                drive_issue(5'((r * 8 + i) % 31 + 1), 1'b0, 1'b0, 32'h0);
                #1;
            end
            next_cycle();
            #1;
            chk("sb.full", rob_bus.rob_full, 1);
            for (int i = 7; i >= 0; i--) begin
                next_cycle();
                drive_wb(3'(i), 32'h1000 * r + i, 1'b0);
                #1;
            end
            got = 0;
            for (int c = 0; c < 20; c++) begin
                next_cycle();
                #1;
                if (rob_bus.rob_commit) begin
                    if (got < 8) begin
                        chk("sb.cent", rob_bus.commit_rob_entry, 32'(got));
                        chk("sb.cid", rob_bus.commit_reg_id, 32'((r * 8 + got) % 31 + 1));
                        chk("sb.cdata", rob_bus.commit_reg_data, 32'h1000 * r + got);
                    end
                    got++;
                end
            end
            chk("sb.count", got, 8);
            chk("sb.empty", rob_bus.rob_empty, 1);
        end

        // Same-cycle writeback bypass on the lookup ports
        do_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            drive_issue(5'(i + 1), 1'b0, 1'b0, 32'h0);
            #1;
        end
        next_cycle();
        drive_wb(3'd4, 32'hDEADBEEF, 1'b0);
        rob_bus.get_rob_entry1 = 3'd4;
        rob_bus.get_rob_entry2 = 3'd3;
        #1;
        chk("byp.ready1", rob_bus.ready1, 1);
        chk("byp.value1", rob_bus.value1, 32'hDEADBEEF);
        chk("byp.ready2", rob_bus.ready2, 0);
        next_cycle();
        rob_bus.get_rob_entry1 = 3'd4;
        rob_bus.get_rob_entry2 = 3'd4;
        #1;
        chk("stored.ready1", rob_bus.ready1, 1);
        chk("stored.value1", rob_bus.value1, 32'hDEADBEEF);
        chk("stored.ready2", rob_bus.ready2, 1);
        chk("stored.value2", rob_bus.value2, 32'hDEADBEEF);

        // Mispredicted branch at entry 1 with entries 2..5 pending
        do_reset();
        next_cycle();
        drive_issue(5'd3, 1'b0, 1'b0, 32'h0);
        #1;
        next_cycle();
        drive_issue(5'd9, 1'b1, 1'b0, 32'h100);
        #1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive_issue(5'(10 + i), 1'b0, 1'b0, 32'h0);
            #1;
        end
        next_cycle();
        drive_wb(3'd0, 32'h55, 1'b0);
        #1;
        next_cycle();
        drive_wb(3'd1, 32'h0, 1'b1);
        #1;
        chk("mp.no_early_clear", rob_bus.rob_clear_up, 0);
        next_cycle();
        #1;
        chk("mp.c0.commit", rob_bus.rob_commit, 1);
        chk("mp.c0.cid", rob_bus.commit_reg_id, 3);
        chk("mp.c0.cdata", rob_bus.commit_reg_data, 32'h55);
        chk("mp.c0.clear", rob_bus.rob_clear_up, 0);
        next_cycle();
        drive_issue(5'd20, 1'b0, 1'b0, 32'h0);
        drive_wb(3'd2, 32'h99, 1'b0);
        #1;
        chk("mp.commit", rob_bus.rob_commit, 1);
        chk("mp.cid", rob_bus.commit_reg_id, 0);
        chk("mp.cent", rob_bus.commit_rob_entry, 1);
        chk("mp.clear", rob_bus.rob_clear_up, 1);
        chk("mp.clear_pc", rob_bus.clear_pc, 32'h100);
        chk("mp.empty", rob_bus.rob_empty, 1);
        chk("mp.entry", rob_bus.issue_rob_entry, 0);
        next_cycle();
        #1;
        chk("mp.pulse_end", rob_bus.rob_clear_up, 0);
        chk("mp.commit_end", rob_bus.rob_commit, 0);
        chk("mp.issue_ignored", rob_bus.issue_rob_entry, 0);
        chk("mp.still_empty", rob_bus.rob_empty, 1);

        // Correctly predicted branch: commit without flush
        next_cycle();
        drive_issue(5'd9, 1'b1, 1'b1, 32'h200);
        #1;
        next_cycle();
        drive_wb(3'd0, 32'h0, 1'b1);
        #1;
        next_cycle();
        #1;
        next_cycle();
        #1;
        chk("okbr.commit", rob_bus.rob_commit, 1);
        chk("okbr.cid", rob_bus.commit_reg_id, 0);
        chk("okbr.clear", rob_bus.rob_clear_up, 0);
        next_cycle();
        #1;
        chk("okbr.entry", rob_bus.issue_rob_entry, 1);
        chk("okbr.empty", rob_bus.rob_empty, 1);
        chk("okbr.no_clear", rob_bus.rob_clear_up, 0);

        // rdy_in low across a ready head
        do_reset();
        next_cycle();
        drive_issue(5'd4, 1'b0, 1'b0, 32'h0);
        #1;
        next_cycle();
        drive_wb(3'd0, 32'h77, 1'b0);
        #1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            rdy_in = 1'b0;
            if (i == 1) drive_issue(5'd8, 1'b0, 1'b0, 32'h0);
            #1;
            chk("stall.no_commit", rob_bus.rob_commit, 0);
        end
        next_cycle();
        rdy_in = 1'b1;
        #1;
        chk("stall.resume_pre", rob_bus.rob_commit, 0);
        next_cycle();
        #1;
        chk("stall.commit", rob_bus.rob_commit, 1);
        chk("stall.cid", rob_bus.commit_reg_id, 4);
        chk("stall.cdata", rob_bus.commit_reg_data, 32'h77);
        next_cycle();
        #1;
        chk("stall.single_pulse", rob_bus.rob_commit, 0);
        chk("stall.empty", rob_bus.rob_empty, 1);
        chk("stall.issue_frozen", rob_bus.issue_rob_entry, 1);

        // Reset asserted in the middle of a commit pulse
        next_cycle();
        drive_issue(5'd6, 1'b0, 1'b0, 32'h0);
        #1;
        next_cycle();
        drive_wb(3'd1, 32'h66, 1'b0);
        #1;
        next_cycle();
        #1;
        next_cycle();
        #1;
        chk("rstmid.commit_before", rob_bus.rob_commit, 1);
        chk("rstmid.cid_before", rob_bus.commit_reg_id, 6);
        #1;
        rst_in = 1'b1;
        #1;
        chk("rstmid.commit_drop", rob_bus.rob_commit, 0);
        chk("rstmid.cid_clear", rob_bus.commit_reg_id, 0);
        chk("rstmid.entry", rob_bus.issue_rob_entry, 0);
        next_cycle();
        rst_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer between the decoder/issue stage and the architectural register file. It allocates one entry per issued instruction and captures results from the common writeback bus. It commits completed entries in program order to the register file, one per cycle. It also serves the register file's two dependency-lookup ports and raises a pipeline-wide flush when a committed branch was mispredicted.

## Interface
- ROB_BIT, 3: entry index width; depth = 2^ROB_BIT (8 entries)
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous, active-high reset
- rdy_in  input  1  ready; low freezes the block
- issue_valid  input  1  decoder requests an entry this cycle
- issue_rd  input  5  destination register (0 = none)
- issue_is_branch  input  1  entry is a conditional branch
- issue_pred_taken  input  1  predictor decision for the branch
- issue_alt_pc  input  32  PC to restart at if the prediction is wrong
- issue_rob_entry  output  ROB_BIT  index being allocated (current tail)
- rob_full  output  1  no free entry; issue is ignored
- rob_empty  output  1  no valid entries
- wb_valid  input  1  writeback bus carries a result
- wb_entry  input  ROB_BIT  entry being completed
- wb_value  input  32  result value
- wb_taken  input  1  actual branch outcome (branches only)
- get_rob_entry1 / get_rob_entry2  input  ROB_BIT  lookup indices from the register file
- ready1 / ready2  output  1  looked-up entry has its result
- value1 / value2  output  32  looked-up result
- rob_commit  output  1  one-cycle commit pulse
- commit_reg_id  output  5  committed destination (0 for branches)
- commit_reg_data  output  32  committed value
- commit_rob_entry  output  ROB_BIT  committed entry index
- rob_clear_up  output  1  one-cycle flush pulse
- clear_pc  output  32  restart PC, valid while rob_clear_up is high

## Operation
- Per-entry state: valid, ready, rd, is_branch, pred_taken, taken, alt_pc, value. Pointers: head, tail (ROB_BIT bits, wrap modulo depth). Counter: count (ROB_BIT+1 bits).
- Issue: when issue_valid && !rob_full, the tail entry is written with valid=1 and ready=0, and tail increments. issue_rob_entry always equals tail.
- Writeback: when wb_valid, the addressed entry gets ready=1, value=wb_value, taken=wb_taken. A writeback to an invalid entry is ignored.
- Lookup (combinational): readyN = ready[get_rob_entryN] || (wb_valid && wb_entry == get_rob_entryN). valueN is wb_value when bypassed, otherwise the stored value. The writeback bypass has priority.
- Commit: when head is valid and ready, the head entry is released and head increments. On the same edge these outputs are registered:
  - rob_commit=1
  - commit_reg_id = rd, or 0 for a branch
  - commit_reg_data = value
  - commit_rob_entry = head
- Mispredict: a committed branch with taken != pred_taken also registers rob_clear_up=1 and clear_pc=alt_pc. On that same edge, every entry's valid is cleared and head=tail=count=0.
- The cycle in which rob_clear_up is high is a flush cycle. Issue and writeback inputs are ignored in it.
- Issue and commit in the same cycle: count is unchanged, and both pointers advance.
- rob_full = (count == 2^ROB_BIT) and is decoded from registered count only. A commit in the same cycle does not free a slot for issue.
- rob_empty = (count == 0).

## Timing
- Reset values: all pointers and count 0; all valid/ready bits 0; rob_commit=0, rob_clear_up=0, commit_reg_id=0, commit_reg_data=0, commit_rob_entry=0, clear_pc=0; rob_empty=1, rob_full=0.
- Reset takes effect immediately and asynchronously. A reset during a commit or flush pulse drops the pulse at once.
- rdy_in low at an edge: all state holds, and rob_commit and rob_clear_up are driven to 0 at that edge. No duplicate commits occur.
- Latency:
  - issue at edge N gives a valid entry after N.
  - writeback at edge M makes lookups ready in cycle M via bypass; the stored ready bit is set after M.
  - If the entry is head, rob_commit is high in the cycle after edge M+1.
- rob_commit and rob_clear_up are single-cycle pulses. At most one commit is made per cycle.
- Writeback to the head entry in the same cycle it arrives does not commit that cycle.

## Test plan
- Reset then idle: rob_empty=1, rob_full=0, rob_commit=0, issue_rob_entry=0.
- Issue 3 writes (rd=5,6,7), writeback entries 2, 0, 1 with values 0x22, 0x00, 0x11 -> commits appear in order entry 0 (x5=0x00), 1 (x6=0x11), 2 (x7=0x22) on consecutive cycles.
- Issue 8 entries -> rob_full=1, and a 9th issue is ignored. Commit 1 and issue 1 -> tail wraps to 0 and issue_rob_entry=0. Fill and drain 3 times with no lost or duplicated entries.
- Lookup entry 4 while wb_valid with wb_entry=4 and wb_value=0xDEADBEEF -> ready1=1 and value1=0xDEADBEEF in the same cycle.
- Branch predicted not-taken at entry 1, wb_taken=1, alt_pc=0x100, with entries 2..5 pending -> rob_commit with commit_reg_id=0, rob_clear_up=1, clear_pc=0x100 for one cycle. Next cycle rob_empty=1 and issue_rob_entry=0. Correctly predicted branch -> no clear.
- Hold rdy_in low across a ready head -> no rob_commit until rdy_in returns. Assert rst_in mid-pulse -> rob_commit drops immediately.
